// File: rtl/matrix_loader.sv
// Streams matrix A then matrix B, row-major, from a valid/ready byte input into
// the shared matrix memory, then hands off to the multiply controller via start.
module matrix_loader #(
  parameter int unsigned N      = 10,
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              mem_owner,
  output logic              write_enable,
  output logic [1:0]        matrix_select,
  output logic [3:0]        row,
  output logic [3:0]        col,
  output logic [DATA_W-1:0] write_data,
  output logic              start,
  input  logic              mc_done,
  output logic              load_done
);

  localparam int unsigned    CNT_W = 4;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD_A,
    LOAD_B,
    FLUSH,
    RUN,
    RELEASE
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] r;
  logic [CNT_W-1:0] c;
  logic             accept;
  logic             at_last;

  // in_ready is only ever high in LOAD_A/LOAD_B, so it gates the accept
  assign accept  = in_valid && in_ready;
  assign at_last = (r == LAST) && (c == LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      r             <= '0;
      c             <= '0;
      in_ready      <= 1'b0;
      mem_owner     <= 1'b0;
      write_enable  <= 1'b0;
      matrix_select <= 2'd0;
      row           <= '0;
      col           <= '0;
      write_data    <= '0;
      start         <= 1'b0;
      load_done     <= 1'b0;
    end else begin
      write_enable <= 1'b0;
      load_done    <= 1'b0;

      case (state)
        IDLE: begin
          if (load) begin
            r         <= '0;
            c         <= '0;
            in_ready  <= 1'b1;
            mem_owner <= 1'b1;
            state     <= LOAD_A;
          end
        end

        LOAD_A, LOAD_B: begin
          if (accept) begin
            write_data    <= in_data;
            row           <= r;
            col           <= c;
            matrix_select <= (state == LOAD_B) ? 2'd1 : 2'd0;
            write_enable  <= 1'b1;

            if (at_last) begin
              r <= '0;
              c <= '0;
              if (state == LOAD_A) begin
                state <= LOAD_B;
              end else begin
                in_ready <= 1'b0;
                state    <= FLUSH;
              end
            end else if (c == LAST) begin
              c <= '0;
              r <= r + CNT_W'(1);
            end else begin
              c <= c + CNT_W'(1);
            end
          end
        end

        // last B write is on the bus this cycle; release the memory next
        FLUSH: begin
          mem_owner <= 1'b0;
          start     <= 1'b1;
          state     <= RUN;
        end

        RUN: begin
          if (mc_done) begin
            start     <= 1'b0;
            load_done <= 1'b1;
            state     <= RELEASE;
          end
        end

        RELEASE: begin
          state <= IDLE;
        end

        default: begin
          in_ready  <= 1'b0;
          mem_owner <= 1'b0;
          start     <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_matrix_loader.sv
// Randomized self-checking bench for matrix_loader against an index-based
// model of where each accepted byte must land in memory.
module tb_matrix_loader;

  localparam int unsigned N      = 10;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned NN     = N * N;
  localparam int unsigned TOTAL  = 2 * NN;

  logic              clk = 1'b0;
  logic              reset;
  logic              load;
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              mem_owner;
  logic              write_enable;
  logic [1:0]        matrix_select;
  logic [3:0]        row;
  logic [3:0]        col;
  logic [DATA_W-1:0] write_data;
  logic              start;
  logic              mc_done;
  logic              load_done;

  int checks = 0;
  int errors = 0;
  bit seen[4][16][16];

  matrix_loader #(.N(N), .DATA_W(DATA_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .load         (load),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .mem_owner    (mem_owner),
    .write_enable (write_enable),
    .matrix_select(matrix_select),
    .row          (row),
    .col          (col),
    .write_data   (write_data),
    .start        (start),
    .mc_done      (mc_done),
    .load_done    (load_done)
  );

  always #5 clk = ~clk;

  // Reset is sampled on the posedge between two negedges; returns at a negedge
  task automatic apply_reset();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic do_load();
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL load_ready: in_ready=%b expected 1", in_ready);
    end
  endtask

  // Streams beats until stop_after accepts; gap_pct = chance of a bubble.
  // Expected write for accept k: matrix k/NN, row (k%NN)/N, col k%N, same byte.
  task automatic stream(input int gap_pct, input int stop_after,
                        input int load_at, input bit idx_data);
    int k;
    int cyc;
    bit acc;
    bit v;
    logic [DATA_W-1:0] d;
    logic [1:0] e_sel;
    logic [3:0] e_row;
    logic [3:0] e_col;
    k = 0;
    cyc = 0;
    for (int s = 0; s < 4; s++)
      for (int i = 0; i < 16; i++)
        for (int j = 0; j < 16; j++) seen[s][i][j] = 1'b0;
    while (k < stop_after && cyc < 5000) begin
      v = ($urandom_range(99) >= 32'(gap_pct));
      d = idx_data ? DATA_W'(k % 256) : DATA_W'($urandom);
      in_valid = v;
      in_data  = d;
      load     = (k == load_at);
      acc      = v && (in_ready === 1'b1);
      e_sel = 2'(k / NN);
      e_row = 4'((k % NN) / N);
      e_col = 4'(k % N);
      @(negedge clk);
      cyc++;
      checks++;
      if (write_enable !== acc) begin
        errors++;
        $display("FAIL we_k%0d: write_enable=%b expected %b", k, write_enable, acc);
      end
      if (acc) begin
        checks++;
        if (write_data !== d || row !== e_row || col !== e_col ||
            matrix_select !== e_sel) begin
          errors++;
          $display("FAIL write_k%0d: sel=%0d row=%0d col=%0d data=%0d expected %0d %0d %0d %0d",
                   k, matrix_select, row, col, write_data, e_sel, e_row, e_col, d);
        end
        checks++;
        if (seen[matrix_select][row][col]) begin
          errors++;
          $display("FAIL dup_addr: sel=%0d row=%0d col=%0d written twice expected once",
                   matrix_select, row, col);
        end
        seen[matrix_select][row][col] = 1'b1;
        k++;
        if (k < int'(TOTAL)) begin
          checks++;
          if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_k%0d: in_ready=%b expected 1", k, in_ready);
          end
        end
      end
    end
    in_valid = 1'b0;
    load     = 1'b0;
    if (k < stop_after) begin
      errors++;
      $display("FAIL stream_timeout: accepted=%0d expected %0d", k, stop_after);
    end
  endtask

  // Called at the negedge right after the last B accept
  task automatic end_check();
    checks++;
    if (in_ready !== 1'b0 || start !== 1'b0 || mem_owner !== 1'b1) begin
      errors++;
      $display("FAIL flush: in_ready=%b start=%b mem_owner=%b expected 0 0 1",
               in_ready, start, mem_owner);
    end
    @(negedge clk);
    checks++;
    if (start !== 1'b1 || mem_owner !== 1'b0 || write_enable !== 1'b0) begin
      errors++;
      $display("FAIL start_rise: start=%b mem_owner=%b we=%b expected 1 0 0",
               start, mem_owner, write_enable);
    end
  endtask

  task automatic check_idle_zero(input string name);
    checks++;
    if ({in_ready, mem_owner, write_enable, start, load_done} !== 5'b0 ||
        matrix_select !== 2'd0 || row !== 4'd0 || col !== 4'd0 ||
        write_data !== '0) begin
      errors++;
      $display("FAIL %s: rdy=%b own=%b we=%b st=%b ld=%b sel=%0d r=%0d c=%0d d=%0d expected all 0",
               name, in_ready, mem_owner, write_enable, start, load_done,
               matrix_select, row, col, write_data);
    end
  endtask

  task automatic test_reset();
    in_valid = 1'b1;
    load     = 1'b0;
    in_data  = '1;
    mc_done  = 1'b0;
    reset    = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    check_idle_zero("reset_values");
    in_valid = 1'b0;
    @(negedge clk);
    check_idle_zero("idle_hold");
    do_load();
  endtask

  task automatic test_gap_free();
    apply_reset();
    do_load();
    stream(0, TOTAL, -1, 1'b1);
    end_check();
  endtask

  task automatic test_handshake();
    mc_done  = 1'b0;
    in_valid = 1'b1;
    in_data  = 8'hAA;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      checks++;
      if (start !== 1'b1 || write_enable !== 1'b0 || in_ready !== 1'b0 ||
          mem_owner !== 1'b0) begin
        errors++;
        $display("FAIL run_hold_%0d: start=%b we=%b rdy=%b own=%b expected 1 0 0 0",
                 i, start, write_enable, in_ready, mem_owner);
      end
    end
    mc_done = 1'b1;
    @(negedge clk);
    mc_done = 1'b0;
    checks++;
    if (start !== 1'b0 || load_done !== 1'b1 || write_enable !== 1'b0) begin
      errors++;
      $display("FAIL release: start=%b load_done=%b we=%b expected 0 1 0",
               start, load_done, write_enable);
    end
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (load_done !== 1'b0 || start !== 1'b0 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL back_idle: load_done=%b start=%b rdy=%b expected 0 0 0",
               load_done, start, in_ready);
    end
    do_load();
  endtask

  task automatic test_back_pressure();
    apply_reset();
    do_load();
    stream(45, TOTAL, -1, 1'b0);
    end_check();
  endtask

  task automatic test_ignored_load();
    apply_reset();
    do_load();
    stream(20, TOTAL, 150, 1'b0);
    end_check();
  endtask

  task automatic test_reset_mid_load();
    apply_reset();
    do_load();
    stream(30, 57, -1, 1'b0);
    apply_reset();
    check_idle_zero("mid_load_reset");
    do_load();
    stream(30, TOTAL - 1, -1, 1'b0);
    checks++;
    if (start !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL early_start: start=%b rdy=%b expected 0 1 after 199 beats",
               start, in_ready);
    end
    apply_reset();
    do_load();
    stream(30, TOTAL, -1, 1'b0);
    end_check();
  endtask

  task automatic test_reset_in_run();
    apply_reset();
    do_load();
    stream(10, TOTAL, -1, 1'b0);
    end_check();
    apply_reset();
    check_idle_zero("run_reset");
  endtask

  initial begin
    test_reset();
    test_gap_free();
    test_handshake();
    test_back_pressure();
    test_ignored_load();
    test_reset_mid_load();
    test_reset_in_run();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
